// File: rtl/out_display_pkg.sv
// Shared definitions for the output display driver: segment codes, FSM states,
// digit indices and the digit-to-segment lookup.
package out_display_pkg;

    localparam int DATA_W = 8;

    // Active-high segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h40;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    localparam logic [1:0] DIG_ONES     = 2'd0;
    localparam logic [1:0] DIG_TENS     = 2'd1;
    localparam logic [1:0] DIG_HUNDREDS = 2'd2;
    localparam logic [1:0] DIG_SIGN     = 2'd3;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    seg_digit = SEG_0;
            4'd1:    seg_digit = SEG_1;
            4'd2:    seg_digit = SEG_2;
            4'd3:    seg_digit = SEG_3;
            4'd4:    seg_digit = SEG_4;
            4'd5:    seg_digit = SEG_5;
            4'd6:    seg_digit = SEG_6;
            4'd7:    seg_digit = SEG_7;
            4'd8:    seg_digit = SEG_8;
            4'd9:    seg_digit = SEG_9;
            default: seg_digit = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/out_display_if.sv
// CPU-side load bus and display-side outputs of the output display driver.
interface out_display_if;
    import out_display_pkg::*;

    logic              load;
    logic [DATA_W-1:0] bus;
    logic              signed_mode;
    logic [DATA_W-1:0] value;
    logic              busy;
    logic [3:0]        digit_select;
    logic [6:0]        segments;

    modport master (
        output load, bus, signed_mode,
        input  value, busy, digit_select, segments
    );

    modport slave (
        input  load, bus, signed_mode,
        output value, busy, digit_select, segments
    );

endinterface

// File: rtl/bin_to_bcd8.sv
// Sequential double-dabble: converts an 8-bit magnitude to three BCD digits,
// one shift per clock, 8 clocks after start.
module bin_to_bcd8
    import out_display_pkg::*;
(
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
    input  logic [DATA_W-1:0] mag,
    output logic              busy,
    output logic              done,
    output logic [3:0]        hundreds,
    output logic [3:0]        tens,
    output logic [3:0]        ones
);

    logic [DATA_W-1:0] shift_q;
    logic [1:0]        hund_q;
    logic [3:0]        tens_q;
    logic [3:0]        ones_q;
    logic [2:0]        iter_q;
    logic              busy_q;

    logic [3:0]        tens_adj;
    logic [3:0]        ones_adj;
    logic [17:0]       shifted;

    // Hundreds never exceeds 2 before a shift, so it needs no add-3 correction
    always_comb begin
        tens_adj = (tens_q >= 4'd5) ? tens_q + 4'd3 : tens_q;
        ones_adj = (ones_q >= 4'd5) ? ones_q + 4'd3 : ones_q;
        shifted  = {hund_q[0], tens_adj, ones_adj, shift_q, 1'b0};
    end

    // done marks the edge on which the final iteration is taken
    assign done     = busy_q && (iter_q == 3'd7);
    assign busy     = busy_q;
    assign hundreds = {2'b00, hund_q};
    assign tens     = tens_q;
    assign ones     = ones_q;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            shift_q <= '0;
            hund_q  <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b0;
        end else if (start) begin
            shift_q <= mag;
            hund_q  <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b1;
        end else if (busy_q) begin
            hund_q  <= shifted[17:16];
            tens_q  <= shifted[15:12];
            ones_q  <= shifted[11:8];
            shift_q <= shifted[7:0];
            iter_q  <= iter_q + 3'd1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/out_display.sv
// Output display driver: captures the output-register byte, converts it to
// signed/unsigned decimal and scans it onto a 4-digit 7-segment display.
module out_display
    import out_display_pkg::*;
#(
    parameter int REFRESH_DIV = 1024
) (
    input  logic         clk,
    input  logic         clear,
    out_display_if.slave io
);

    localparam int               CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    state_t            state_q;
    logic              busy_q;
    logic [DATA_W-1:0] value_q;
    logic              neg_q;

    logic signed [DATA_W-1:0] bus_s;
    logic                     neg_in;
    logic [DATA_W-1:0]        mag_in;

    logic       cvt_busy;
    logic       cvt_done;
    logic [3:0] cvt_hund;
    logic [3:0] cvt_tens;
    logic [3:0] cvt_ones;

    logic [3:0] disp_hund_q, disp_tens_q, disp_ones_q;
    logic       disp_neg_q;
    logic [3:0] disp_hund_d, disp_tens_d, disp_ones_d;
    logic       disp_neg_d;
    logic       commit;

    logic [CNT_W-1:0] refresh_q;
    logic [1:0]       idx_q;
    logic [1:0]       idx_next;
    logic             wrap;
    logic [3:0]       digit_select_q;
    logic [6:0]       segments_q;

    // Two's-complement negation of 0x80 wraps back to 0x80, giving magnitude 128
    always_comb begin
        bus_s  = signed'(io.bus);
        neg_in = io.signed_mode & io.bus[DATA_W-1];
        mag_in = neg_in ? DATA_W'(-bus_s) : io.bus;
    end

    bin_to_bcd8 u_bcd (
        .clk      (clk),
        .clear    (clear),
        .start    (io.load),
        .mag      (mag_in),
        .busy     (cvt_busy),
        .done     (cvt_done),
        .hundreds (cvt_hund),
        .tens     (cvt_tens),
        .ones     (cvt_ones)
    );

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            value_q <= '0;
            neg_q   <= 1'b0;
        end else if (io.load) begin
            state_q <= CONVERT;
            busy_q  <= 1'b1;
            value_q <= io.bus;
            neg_q   <= neg_in;
        end else begin
            case (state_q)
                CONVERT: if (cvt_busy && cvt_done) state_q <= COMMIT;
                COMMIT: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // A load on the commit edge restarts conversion and suppresses the commit
    always_comb begin
        commit      = (state_q == COMMIT) && !io.load;
        disp_hund_d = commit ? cvt_hund : disp_hund_q;
        disp_tens_d = commit ? cvt_tens : disp_tens_q;
        disp_ones_d = commit ? cvt_ones : disp_ones_q;
        disp_neg_d  = commit ? neg_q    : disp_neg_q;
        wrap        = (refresh_q == CNT_LAST);
        idx_next    = wrap ? idx_q + 2'd1 : idx_q;
    end

    function automatic logic [6:0] digit_code(
        input logic [1:0] idx,
        input logic [3:0] hund,
        input logic [3:0] tens,
        input logic [3:0] ones,
        input logic       neg
    );
        case (idx)
            DIG_ONES:     digit_code = seg_digit(ones);
            DIG_TENS:     digit_code = (hund == 4'd0 && tens == 4'd0) ? SEG_BLANK : seg_digit(tens);
            DIG_HUNDREDS: digit_code = (hund == 4'd0) ? SEG_BLANK : seg_digit(hund);
            default:      digit_code = neg ? SEG_MINUS : SEG_BLANK;
        endcase
    endfunction

    // Segment code is built from the next display contents so it never lags a commit
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            disp_hund_q    <= '0;
            disp_tens_q    <= '0;
            disp_ones_q    <= '0;
            disp_neg_q     <= 1'b0;
            refresh_q      <= '0;
            idx_q          <= DIG_ONES;
            digit_select_q <= 4'b0001;
            segments_q     <= SEG_0;
        end else begin
            disp_hund_q    <= disp_hund_d;
            disp_tens_q    <= disp_tens_d;
            disp_ones_q    <= disp_ones_d;
            disp_neg_q     <= disp_neg_d;
            refresh_q      <= wrap ? '0 : refresh_q + 1'b1;
            idx_q          <= idx_next;
            digit_select_q <= 4'b0001 << idx_next;
            segments_q     <= digit_code(idx_next, disp_hund_d, disp_tens_d, disp_ones_d, disp_neg_d);
        end
    end

    assign io.value        = value_q;
    assign io.busy         = busy_q;
    assign io.digit_select = digit_select_q;
    assign io.segments     = segments_q;

endmodule

// File: tb/tb_out_display.sv
// Directed testbench for out_display with a 4-cycle refresh divider.
module tb_out_display;

    logic clk;
    logic clear;
    int   checks;
    int   failures;
    bit   mon5;
    bit   seen5;

    out_display_if ifc ();

    out_display #(.REFRESH_DIV(4)) dut (
        .clk   (clk),
        .clear (clear),
        .io    (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon5 && ifc.segments == 7'h6D) seen5 = 1'b1;
    end

    task automatic get_seg(input logic [3:0] mask, output logic [6:0] seg, output bit ok);
        ok  = 1'b0;
        seg = '0;
        for (int i = 0; i < 16 && !ok; i++) begin
            @(negedge clk);
            if (ifc.digit_select === mask) begin
                seg = ifc.segments;
                ok  = 1'b1;
            end
        end
    endtask

    task automatic do_load(input logic [7:0] b, input logic m);
        @(posedge clk);
        #1;
        ifc.load        = 1'b1;
        ifc.bus         = b;
        ifc.signed_mode = m;
        @(posedge clk);
        #1;
        ifc.load = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ifc.busy === 1'b1) n++;
            else break;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if (ifc.digit_select !== 4'b0001) begin
            failures++; $display("FAIL reset_dsel actual=%b required=0001", ifc.digit_select);
        end
        checks++;
        if (ifc.segments !== 7'h3F) begin
            failures++; $display("FAIL reset_seg actual=%h required=3f", ifc.segments);
        end
        checks++;
        if (ifc.busy !== 1'b0 || ifc.value !== 8'h00) begin
            failures++; $display("FAIL reset_busy_value actual=%b/%h required=0/00", ifc.busy, ifc.value);
        end
        clear = 1'b0;
    endtask

    task automatic test_unsigned_123;
        int n;
        logic [3:0] masks [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [6:0] exp   [4] = '{7'h4F, 7'h5B, 7'h06, 7'h00};
        logic [6:0] s;
        bit ok;
        do_load(8'h7B, 1'b0);
        count_busy(n);
        checks++;
        if (n != 9) begin
            failures++; $display("FAIL u123_busy_cycles actual=%0d required=9", n);
        end
        checks++;
        if (ifc.value !== 8'h7B) begin
            failures++; $display("FAIL u123_value actual=%h required=7b", ifc.value);
        end
        for (int i = 0; i < 4; i++) begin
            get_seg(masks[i], s, ok);
            checks++;
            if (!ok || s !== exp[i]) begin
                failures++; $display("FAIL u123_digit%0d actual=%h found=%0d required=%h", i, s, ok, exp[i]);
            end
        end
    endtask

    task automatic test_extremes;
        logic [7:0] bytes [3] = '{8'h80, 8'hFF, 8'hFF};
        logic       modes [3] = '{1'b1, 1'b0, 1'b1};
        logic [6:0] exp [3][4] = '{'{7'h7F, 7'h5B, 7'h06, 7'h40},
                                   '{7'h6D, 7'h6D, 7'h5B, 7'h00},
                                   '{7'h06, 7'h00, 7'h00, 7'h40}};
        logic [6:0] s;
        bit ok;
        int n;
        for (int t = 0; t < 3; t++) begin
            do_load(bytes[t], modes[t]);
            count_busy(n);
            checks++;
            if (n != 9 || ifc.value !== bytes[t]) begin
                failures++; $display("FAIL ext%0d_busy_value actual=%0d/%h required=9/%h", t, n, ifc.value, bytes[t]);
            end
            for (int i = 0; i < 4; i++) begin
                get_seg(4'b0001 << i, s, ok);
                checks++;
                if (!ok || s !== exp[t][i]) begin
                    failures++; $display("FAIL ext%0d_digit%0d actual=%h found=%0d required=%h", t, i, s, ok, exp[t][i]);
                end
            end
        end
    endtask

    task automatic test_restart;
        int n;
        logic [6:0] exp [4] = '{7'h5B, 7'h66, 7'h00, 7'h00};
        logic [6:0] s;
        bit ok;
        seen5 = 1'b0;
        mon5  = 1'b1;
        do_load(8'h05, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (ifc.busy !== 1'b1) begin
            failures++; $display("FAIL restart_busy_3rd actual=%b required=1", ifc.busy);
        end
        ifc.load = 1'b1;
        ifc.bus  = 8'h2A;
        @(posedge clk);
        #1;
        ifc.load = 1'b0;
        count_busy(n);
        checks++;
        if (n != 9) begin
            failures++; $display("FAIL restart_busy_cycles actual=%0d required=9", n);
        end
        for (int i = 0; i < 4; i++) begin
            get_seg(4'b0001 << i, s, ok);
            checks++;
            if (!ok || s !== exp[i]) begin
                failures++; $display("FAIL restart_digit%0d actual=%h found=%0d required=%h", i, s, ok, exp[i]);
            end
        end
        mon5 = 1'b0;
        checks++;
        if (seen5 !== 1'b0) begin
            failures++; $display("FAIL restart_shows5 actual=%b required=0", seen5);
        end
    endtask

    task automatic test_scan_cadence;
        logic [3:0] prev, cur, expd;
        bit synced;
        int n;
        synced = 1'b0;
        prev   = ifc.digit_select;
        fork
            begin
                for (int k = 0; k < 48; k++) begin
                    @(posedge clk);
                    #1;
                    ifc.load = ~ifc.load;
                    ifc.bus  = 8'(k * 37);
                end
                ifc.load = 1'b0;
            end
            begin
                for (int i = 0; i < 40 && !synced; i++) begin
                    @(negedge clk);
                    cur = ifc.digit_select;
                    if (prev == 4'b1000 && cur == 4'b0001) synced = 1'b1;
                    prev = cur;
                end
                checks++;
                if (!synced) begin
                    failures++; $display("FAIL scan_sync actual=%b required=1000->0001", prev);
                end else begin
                    for (int i = 1; i <= 16; i++) begin
                        @(negedge clk);
                        expd = 4'b0001 << ((i / 4) % 4);
                        checks++;
                        if (ifc.digit_select !== expd) begin
                            failures++; $display("FAIL scan_step%0d actual=%b required=%b", i, ifc.digit_select, expd);
                        end
                    end
                end
            end
        join
        count_busy(n);
        checks++;
        if (ifc.busy !== 1'b0) begin
            failures++; $display("FAIL scan_settle actual=%b required=0", ifc.busy);
        end
    endtask

    task automatic test_reset_mid_conversion;
        logic [6:0] s;
        bit ok;
        do_load(8'hC8, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #3;
        clear = 1'b1;
        #1;
        checks++;
        if (ifc.digit_select !== 4'b0001 || ifc.segments !== 7'h3F) begin
            failures++; $display("FAIL midclr_display actual=%b/%h required=0001/3f", ifc.digit_select, ifc.segments);
        end
        checks++;
        if (ifc.busy !== 1'b0 || ifc.value !== 8'h00) begin
            failures++; $display("FAIL midclr_busy_value actual=%b/%h required=0/00", ifc.busy, ifc.value);
        end
        repeat (2) @(negedge clk);
        clear = 1'b0;
        repeat (15) @(negedge clk);
        checks++;
        if (ifc.busy !== 1'b0 || ifc.value !== 8'h00) begin
            failures++; $display("FAIL midclr_after_busy_value actual=%b/%h required=0/00", ifc.busy, ifc.value);
        end
        get_seg(4'b0001, s, ok);
        checks++;
        if (!ok || s !== 7'h3F) begin
            failures++; $display("FAIL midclr_ones actual=%h found=%0d required=3f", s, ok);
        end
        get_seg(4'b0100, s, ok);
        checks++;
        if (!ok || s !== 7'h00) begin
            failures++; $display("FAIL midclr_hundreds actual=%h found=%0d required=00", s, ok);
        end
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        mon5            = 1'b0;
        seen5           = 1'b0;
        clear           = 1'b1;
        ifc.load        = 1'b0;
        ifc.bus         = 8'h00;
        ifc.signed_mode = 1'b0;
        test_reset;
        test_unsigned_123;
        test_extremes;
        test_restart;
        test_scan_cadence;
        test_reset_mid_conversion;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
